dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: the core's memory stage (port c_) and a DMA/debug loader (port d_).
- Sequences every access through an IDLE/ACCESS/WAIT/DONE state machine.
- Supports a configurable memory read latency.
- Returns read data and a one-cycle done pulse to the owner of each access.
- Drives c_stall so the core pipeline freezes while its access is pending.

Parameters:
- RD_LAT, 1, data memory read latency in cycles from m_rd_en to valid m_rdata; legal range 0..3.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- c_req  in  1  core requests an access; held until c_done.
- c_we  in  1  1 = store, 0 = load.
- c_mem_type  in  3  access size/sign code, passed through unchanged.
- c_addr  in  AW  byte address.
- c_wdata  in  DW  store data.
- c_done  out  1  one-cycle completion pulse.
- c_rdata  out  DW  load data; valid while c_done=1.
- c_stall  out  1  c_req & ~c_done (combinational).
- d_req, d_we, d_mem_type, d_addr, d_wdata, d_done, d_rdata  same as c_ for the DMA port.
- m_rd_en  out  1  memory read enable.
- m_wr_en  out  1  memory write enable.
- m_mem_type  out  3  to memory.
- m_addr  out  AW  to memory.
- m_wdata  out  DW  to memory.
- m_rdata  in  DW  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, last_owner=DMA (so the core wins the first tie), all latched fields=0, all outputs=0.
- IDLE state:
  - If any req is high, pick a winner and latch owner, we, mem_type, addr, wdata at the clock edge, then go to ACCESS.
  - Only one requesting: that requester wins.
  - Both requesting: winner = the port that is not last_owner (round-robin).
  - last_owner updates on every grant.
- ACCESS state (exactly 1 cycle):
  - m_addr, m_wdata and m_mem_type are driven from the latched registers; they are 0 in every state other than ACCESS and WAIT.
  - Store: m_wr_en=1 for this cycle only, then go to DONE.
  - Load with RD_LAT=0: m_rd_en=1; capture m_rdata this cycle; go to DONE.
  - Load with RD_LAT>=1: m_rd_en=1; load the counter with RD_LAT-1; go to WAIT.
- WAIT state:
  - m_rd_en=0; address fields stay stable.
  - When counter=0, capture m_rdata into the rdata register and go to DONE; otherwise decrement the counter.
- DONE state (1 cycle):
  - Owner's x_done=1; x_rdata = captured data (0 for stores).
  - The non-owner's done=0 and its rdata=0.
  - Next state is IDLE.
- Latency:
  - Store: req seen in IDLE at cycle 0 -> m_wr_en at cycle 1 -> done at cycle 2.
  - Load: done at cycle 2+RD_LAT.
  - Back-to-back accesses from alternating requesters: one access every 3+RD_LAT cycles (loads) or 3 cycles (stores).
- Requester rules:
  - Hold req and all fields stable from assertion until done is sampled.
  - Deassert req in the cycle after done, or keep it high to request a new access; it is then re-arbitrated in IDLE as a fresh request.
- Owner drops req mid-access: the access still completes and done still pulses. The latched fields, not live inputs, drive memory.
- Non-owner asserting req during an access: it waits. Its stall stays high; no fields are sampled until IDLE.
- Starvation: with both requesting continuously, grants strictly alternate.
- Reset mid-operation: state returns to IDLE immediately and asynchronously, and m_wr_en/m_rd_en drop at once. An in-flight access is abandoned with no done pulse.
- No alignment or address-range checking; mem_type and addr pass through unchanged.

Test Plan:
- Single core store, RD_LAT=1: c_req, c_we=1, c_addr=0x10, c_wdata=0xDEADBEEF at cycle 0 -> m_wr_en=1 with the same addr/data at cycle 1 only; c_done=1 at cycle 2; c_stall=1 during cycles 0-1.
- Core load, RD_LAT=2, memory returns 0x12345678 two cycles after m_rd_en -> m_rd_en at cycle 1; c_done=1 with c_rdata=0x12345678 at cycle 4; d_done stays 0.
- Both requesting from reset, stores, held continuously -> grant order core, DMA, core, DMA; done pulses at cycles 2, 5, 8, 11.
- DMA access in flight, core asserts c_req mid-access -> core is granted in the first IDLE after d_done; the core's fields are sampled only then; c_stall is high throughout the wait.
- Owner drops req in WAIT (RD_LAT=3) -> access still completes; done pulses once at the expected cycle 5.
- rst pulsed asynchronously during ACCESS of a store -> m_wr_en falls without waiting for a clock edge; busy=0; no done pulse; the next request is served normally with core priority.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data memory between the core memory stage (c_*) and a
//   DMA/debug loader (d_*). Each access runs IDLE -> ACCESS -> [WAIT] -> DONE.
//   The owner's fields are latched at grant, so the memory sees stable values
//   even if the live requester inputs move. Ties go round-robin.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   c_req/c_we/c_mem_type/c_addr/c_wdata   core request fields
//   c_done, c_rdata     one-cycle completion pulse and load data
//   c_stall             c_req & ~c_done, freezes the core pipeline
//   d_*                 same set for the DMA/debug port (no stall output)
//   m_rd_en, m_wr_en, m_mem_type, m_addr, m_wdata, m_rdata   memory side
//   busy                high whenever the sequencer is not idle
//
// Parameters
//   RD_LAT  memory read latency in cycles from m_rd_en to valid m_rdata (0..3)
//   AW, DW  address and data widths
module dmem_arbiter #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  // core port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [2:0]    c_mem_type,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_done,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  // DMA / debug port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_mem_type,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  // memory side
  output logic          m_rd_en,
  output logic          m_wr_en,
  output logic [2:0]    m_mem_type,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;

  // Wait-counter preload; ACCESS itself is the first latency cycle.
  localparam logic [1:0] CNT_INIT = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic          owner_q;
  logic          last_owner_q;
  logic          we_q;
  logic [2:0]    mem_type_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    cnt_q;

  logic          grant;
  logic          grant_dma;
  logic          capture;
  logic          cnt_load;
  logic          cnt_dec;

  // Arbitration: a lone requester wins; on a tie the port that did not
  // own the previous access wins.
  always_comb begin
    grant     = c_req | d_req;
    grant_dma = 1'b0;
    if (c_req && d_req) begin
      grant_dma = (last_owner_q == OWN_CORE);
    end else begin
      grant_dma = d_req;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_DONE;
        end else if (RD_LAT == 0) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_load = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant latch, read-data capture and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= OWN_CORE;
      last_owner_q <= OWN_DMA;
      we_q         <= 1'b0;
      mem_type_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      if (state_q == S_IDLE && grant) begin
        owner_q      <= grant_dma;
        last_owner_q <= grant_dma;
        we_q         <= grant_dma ? d_we       : c_we;
        mem_type_q   <= grant_dma ? d_mem_type : c_mem_type;
        addr_q       <= grant_dma ? d_addr     : c_addr;
        wdata_q      <= grant_dma ? d_wdata    : c_wdata;
        // Stores report zero read data.
        rdata_q      <= '0;
      end
      if (capture) begin
        rdata_q <= m_rdata;
      end
      if (cnt_load) begin
        cnt_q <= CNT_INIT;
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - 2'd1;
      end
    end
  end

  // Outputs are decoded from the state register alone, so an asynchronous
  // reset removes the memory strobes immediately.
  always_comb begin
    m_rd_en    = 1'b0;
    m_wr_en    = 1'b0;
    m_mem_type = '0;
    m_addr     = '0;
    m_wdata    = '0;
    c_done     = 1'b0;
    d_done     = 1'b0;
    c_rdata    = '0;
    d_rdata    = '0;
    busy       = (state_q != S_IDLE);
    if (state_q == S_ACCESS || state_q == S_WAIT) begin
      m_mem_type = mem_type_q;
      m_addr     = addr_q;
      m_wdata    = wdata_q;
    end
    if (state_q == S_ACCESS) begin
      m_wr_en = we_q;
      m_rd_en = ~we_q;
    end
    if (state_q == S_DONE) begin
      if (owner_q == OWN_DMA) begin
        d_done  = 1'b1;
        d_rdata = rdata_q;
      end else begin
        c_done  = 1'b1;
        c_rdata = rdata_q;
      end
    end
  end

  assign c_stall = c_req & ~c_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed scenarios for reset, latency, round-robin, mid-access requests,
//   owner drop and asynchronous reset, followed by a randomized two-port run
//   checked by a scoreboard. The reference model works at transaction level:
//   each requester queues its expected result as it issues, a monitor predicts
//   the grant winner from the request pattern seen in the idle cycle and pops
//   the winner's entry when its done pulse is due.
module tb_dmem_arbiter;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, d_req, d_we;
  logic [2:0]    c_mem_type, d_mem_type;
  logic [31:0]   c_addr, c_wdata, d_addr, d_wdata;
  logic          c_done, c_stall, d_done;
  logic [31:0]   c_rdata, d_rdata;
  logic          m_rd_en, m_wr_en, busy;
  logic [2:0]    m_mem_type;
  logic [31:0]   m_addr, m_wdata, m_rdata;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.RD_LAT(RD_LAT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_mem_type(c_mem_type), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_done(c_done), .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_mem_type(d_mem_type), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_mem_type(m_mem_type),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Background contents of never-written words; 0x20 holds a known pattern.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h20) return 32'h12345678;
    return a * 32'h9E3779B1 + 32'h1234;
  endfunction

  // Memory model: writes on m_wr_en, read data valid RD_LAT(=2) cycles
  // after m_rd_en and garbage otherwise.
  logic [31:0]  tb_mem [256];
  logic [255:0] wr_vld;
  logic         rv0 = 1'b0, rv1 = 1'b0;
  logic [31:0]  ra0 = '0, ra1 = '0;

  always @(posedge clk) begin
    rv0 <= m_rd_en;
    ra0 <= m_addr;
    rv1 <= rv0;
    ra1 <= ra0;
    if (rst) begin
      wr_vld <= '0;
    end else if (m_wr_en) begin
      tb_mem[m_addr[9:2]] <= m_wdata;
      wr_vld[m_addr[9:2]] <= 1'b1;
    end
  end

  assign m_rdata = !rv1 ? 32'hBADDF00D :
                   (wr_vld[ra1[9:2]] ? tb_mem[ra1[9:2]] : init_val(ra1));

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        we;
    logic [2:0]  mt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } txn_t;

  txn_t        q_c[$];
  txn_t        q_d[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic        mon_en = 1'b0;

  logic        mlast, mact, mown, pc, pd;
  int          mk, mdone_at;
  txn_t        mt_cur;

  always @(negedge clk) begin
    if (!mon_en) begin
      mlast = 1'b1;
      mact  = 1'b0;
      pc    = 1'b0;
      pd    = 1'b0;
    end else begin
      chk("stall_rule", {31'd0, c_stall}, {31'd0, c_req & ~c_done});
      if (mact) begin
        mk++;
        if (mk == mdone_at) begin
          chk("done_core", {31'd0, c_done}, {31'd0, ~mown});
          chk("done_dma",  {31'd0, d_done}, {31'd0, mown});
          if (!mown && q_c.size() > 0) begin
            mt_cur = q_c.pop_front();
            chk("rdata_core", c_rdata, mt_cur.exp);
            chk("rdata_dma_idle", d_rdata, 32'h0);
          end else if (mown && q_d.size() > 0) begin
            mt_cur = q_d.pop_front();
            chk("rdata_dma", d_rdata, mt_cur.exp);
            chk("rdata_core_idle", c_rdata, 32'h0);
          end
          mact = 1'b0;
        end else begin
          chk("early_done", {30'd0, c_done, d_done}, 32'h0);
          chk("busy_in_access", {31'd0, busy}, 32'h1);
        end
      end else if (busy) begin
        chk("grant_had_req", {31'd0, pc | pd}, 32'h1);
        mown  = (pc && pd) ? ~mlast : pd;
        mlast = mown;
        mact  = 1'b1;
        mk    = 0;
        chk("grant_queue", mown ? q_d.size() : q_c.size(), 32'h1);
        if ((mown ? q_d.size() : q_c.size()) > 0) begin
          mt_cur = mown ? q_d[0] : q_c[0];
          chk("grant_addr", m_addr, mt_cur.addr);
          chk("grant_type", {29'd0, m_mem_type}, {29'd0, mt_cur.mt});
          chk("grant_wr", {30'd0, m_wr_en, m_rd_en}, {30'd0, mt_cur.we, ~mt_cur.we});
          if (mt_cur.we) chk("grant_wdata", m_wdata, mt_cur.wdata);
          mdone_at = mt_cur.we ? 1 : 1 + int'(RD_LAT);
        end else begin
          mdone_at = 1;
        end
      end else begin
        chk("idle_done", {30'd0, c_done, d_done}, 32'h0);
      end
      pc = c_req;
      pd = d_req;
    end
  end

  task automatic drive(input int p, input logic req, input logic we, input logic [2:0] mt,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      c_req = req; c_we = we; c_mem_type = mt; c_addr = addr; c_wdata = wdata;
    end else begin
      d_req = req; d_we = we; d_mem_type = mt; d_addr = addr; d_wdata = wdata;
    end
  endtask

  task automatic run_port(input int p, input int n);
    txn_t t;
    int   gap;
    logic got;
    for (int i = 0; i < n; i++) begin
      t.we    = 1'($urandom_range(0, 1));
      t.mt    = 3'($urandom_range(0, 7));
      t.addr  = (p == 0 ? 32'h100 : 32'h200) + 32'(4 * $urandom_range(0, 7));
      t.wdata = $urandom;
      if (t.we) begin
        t.exp = '0;
        ref_mem[t.addr] = t.wdata;
      end else begin
        t.exp = ref_mem.exists(t.addr) ? ref_mem[t.addr] : init_val(t.addr);
      end
      if (p == 0) q_c.push_back(t);
      else        q_d.push_back(t);
      drive(p, 1'b1, t.we, t.mt, t.addr, t.wdata);
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        @(negedge clk);
        got = (p == 0) ? c_done : d_done;
      end
      chk(p == 0 ? "timeout_core" : "timeout_dma", {31'd0, got}, 32'h1);
      @(posedge clk); #1;
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        drive(p, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    drive(p, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_strobes", {30'd0, m_wr_en, m_rd_en}, 32'h0);
    chk("rst_dones", {30'd0, c_done, d_done}, 32'h0);
    chk("rst_addr", m_addr, 32'h0);

    // Single core store
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("st0_stall", {31'd0, c_stall}, 32'h1);
    chk("st0_wr", {31'd0, m_wr_en}, 32'h0);
    chk("st0_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    chk("st1_wr", {31'd0, m_wr_en}, 32'h1);
    chk("st1_rd", {31'd0, m_rd_en}, 32'h0);
    chk("st1_addr", m_addr, 32'h10);
    chk("st1_wdata", m_wdata, 32'hDEADBEEF);
    chk("st1_type", {29'd0, m_mem_type}, 32'h2);
    chk("st1_stall", {31'd0, c_stall}, 32'h1);
    @(negedge clk);
    chk("st2_done", {31'd0, c_done}, 32'h1);
    chk("st2_rdata", c_rdata, 32'h0);
    chk("st2_stall", {31'd0, c_stall}, 32'h0);
    chk("st2_wr", {31'd0, m_wr_en}, 32'h0);
    chk("st2_addr", m_addr, 32'h0);
    chk("st2_ddone", {31'd0, d_done}, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("st3_done", {31'd0, c_done}, 32'h0);
    chk("st3_busy", {31'd0, busy}, 32'h0);

    // Core load, RD_LAT=2
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 3'd4, 32'h20, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("ld1_rd", {31'd0, m_rd_en}, 32'h1);
    chk("ld1_addr", m_addr, 32'h20);
    chk("ld1_type", {29'd0, m_mem_type}, 32'h4);
    @(negedge clk);
    chk("ld2_rd", {31'd0, m_rd_en}, 32'h0);
    chk("ld2_addr", m_addr, 32'h20);
    chk("ld2_busy", {31'd0, busy}, 32'h1);
    chk("ld2_done", {31'd0, c_done}, 32'h0);
    @(negedge clk);
    chk("ld3_done", {31'd0, c_done}, 32'h0);
    @(negedge clk);
    chk("ld4_done", {31'd0, c_done}, 32'h1);
    chk("ld4_rdata", c_rdata, 32'h12345678);
    chk("ld4_ddone", {31'd0, d_done}, 32'h0);
    chk("ld4_drdata", d_rdata, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

    // Both requesting stores from reset: core, DMA, core, DMA
    do_reset();
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 3'd0, 32'h30, 32'hAAAA0001);
    drive(1, 1'b1, 1'b1, 3'd1, 32'h40, 32'hBBBB0002);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      chk($sformatf("rr_cdone_%0d", cyc), {31'd0, c_done}, {31'd0, cyc == 2 || cyc == 8});
      chk($sformatf("rr_ddone_%0d", cyc), {31'd0, d_done}, {31'd0, cyc == 5 || cyc == 11});
      if (cyc == 1 || cyc == 7) chk("rr_addr_core", m_addr, 32'h30);
      if (cyc == 4 || cyc == 10) chk("rr_addr_dma", m_addr, 32'h40);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

    // DMA load in flight; core requests mid-access
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 3'd2, 32'h50, 32'h0);
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      if (cyc == 2) drive(0, 1'b1, 1'b1, 3'd5, 32'h60, 32'hCAFE0001);
      if (cyc == 5) drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("mid_ddone_%0d", cyc), {31'd0, d_done}, {31'd0, cyc == 4});
      chk($sformatf("mid_cdone_%0d", cyc), {31'd0, c_done}, {31'd0, cyc == 7});
      if (cyc >= 2 && cyc <= 6) chk($sformatf("mid_stall_%0d", cyc), {31'd0, c_stall}, 32'h1);
      if (cyc == 1) chk("mid_dma_addr", m_addr, 32'h50);
      if (cyc == 4) chk("mid_dma_rdata", d_rdata, init_val(32'h50));
      if (cyc == 6) begin
        chk("mid_core_addr", m_addr, 32'h60);
        chk("mid_core_wr", {31'd0, m_wr_en}, 32'h1);
        chk("mid_core_wdata", m_wdata, 32'hCAFE0001);
      end
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

    // Owner drops req while in WAIT
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 3'd0, 32'h70, 32'h0);
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      if (cyc == 2) c_req = 1'b0;
      @(negedge clk);
      chk($sformatf("drop_cdone_%0d", cyc), {31'd0, c_done}, {31'd0, cyc == 4});
      if (cyc == 1) chk("drop_addr", m_addr, 32'h70);
      if (cyc == 4) chk("drop_rdata", c_rdata, init_val(32'h70));
      if (cyc >= 5) chk("drop_idle", {31'd0, busy}, 32'h0);
    end

    // Asynchronous reset during ACCESS of a store
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 3'd0, 32'h78, 32'h55);
    @(posedge clk); #2;
    chk("arst_pre_wr", {31'd0, m_wr_en}, 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_wr", {31'd0, m_wr_en}, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'h0);
    chk("arst_addr", m_addr, 32'h0);
    c_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      chk("arst_nodone", {29'd0, c_done, d_done, busy}, 32'h0);
    end
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 3'd0, 32'h80, 32'h11);
    drive(1, 1'b1, 1'b1, 3'd0, 32'h90, 32'h22);
    @(negedge clk);
    @(negedge clk);
    chk("arst_prio_addr", m_addr, 32'h80);
    chk("arst_prio_wr", {31'd0, m_wr_en}, 32'h1);
    @(negedge clk);
    chk("arst_prio_done", {30'd0, c_done, d_done}, 32'h2);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

    // Randomized two-port traffic under the scoreboard
    do_reset();
    @(posedge clk); #1;
    mon_en = 1'b1;
    fork
      run_port(0, 40);
      run_port(1, 40);
    join
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    chk("queue_core_empty", q_c.size(), 32'h0);
    chk("queue_dma_empty", q_d.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
